// File: rtl/gauss_coef_ctrl_if.sv
// Parameter bus of the Gaussian coefficient controller.
//   iparam_wr        write strobe, one write per asserted cycle
//   iaddr_parameter  register address
//   idata_parameter  write data
// master: the bus owner (CPU bridge / testbench); slave: gauss_coef_ctrl.
interface gauss_coef_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              iparam_wr;
    logic [ADDR_W-1:0] iaddr_parameter;
    logic [15:0]       idata_parameter;

    modport master (output iparam_wr, iaddr_parameter, idata_parameter);
    modport slave  (input  iparam_wr, iaddr_parameter, idata_parameter);
endinterface

// File: rtl/gauss_coef_ctrl.sv
// Configuration controller for the 3x3 Gaussian filter datapath.
// A shadow coefficient bank is written over the parameter bus. A commit
// command sums the shadow coefficients serially; if the sum equals G_SUM the
// controller arms and copies the shadow bank (plus enable) into the active
// bank on the next frame-sync rising edge, so a kernel never changes inside
// a frame. With the filter disabled the output is an identity kernel.
//
// Ports:
//   iclk       clock
//   rst_i      synchronous active-high reset
//   pbus       parameter bus (write strobe, address, data)
//   isync      frame sync from the video timing
//   og_data    active kernel, coefficient k at [(k+1)*G_DATAWIDTH-1 : k*G_DATAWIDTH]
//   ogauss_on  active filter enable
//   obusy      commit in progress (SUM, CHECK, ARMED)
//   ocommit    one-cycle pulse when the active bank is updated
//   oerr       sticky sum-mismatch flag, cleared by the next commit
module gauss_coef_ctrl #(
    parameter int              N           = 3,
    parameter int              M           = 3,
    parameter int              G_DATAWIDTH = 10,
    parameter int              G_SUM       = 256,
    parameter int              ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] ADDR_COEF = 'h0200,
    parameter logic [ADDR_W-1:0] ADDR_ON   = 'h001C,
    parameter logic [ADDR_W-1:0] ADDR_CMD  = 'h001F
) (
    input  logic                         iclk,
    input  logic                         rst_i,
    gauss_coef_ctrl_if.slave             pbus,
    input  logic                         isync,
    output logic [G_DATAWIDTH*N*M-1:0]   og_data,
    output logic                         ogauss_on,
    output logic                         obusy,
    output logic                         ocommit,
    output logic                         oerr
);
    localparam int K      = N * M;
    localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;
    // Sum of K coefficients of G_DATAWIDTH bits cannot overflow this width.
    localparam int ACC_W  = G_DATAWIDTH + $clog2(K);
    localparam int CENTER = (K - 1) / 2;

    typedef enum logic [1:0] {IDLE, SUM, CHECK, ARMED} state_t;

    state_t                 state, state_next;
    logic [G_DATAWIDTH-1:0] shadow [K];
    logic [G_DATAWIDTH-1:0] active [K];
    logic                   shadow_on, active_on;
    logic [ACC_W-1:0]       acc;
    logic [IDX_W-1:0]       idx;
    logic                   isync_d;

    // Default smoothing kernel: weight doubles on the centre row and centre
    // column, giving 16/32/64 at 3x3 (sum 256).
    function automatic logic [G_DATAWIDTH-1:0] default_coef(input int k);
        int wr;
        int wc;
        wr = ((k / M) == (N - 1) / 2) ? 2 : 1;
        wc = ((k % M) == (M - 1) / 2) ? 2 : 1;
        return G_DATAWIDTH'(16 * wr * wc);
    endfunction

    // Bus decode
    logic [ADDR_W-1:0] coef_off;
    logic              wr_coef, wr_on, wr_cmd, cmd_commit, cmd_abort, sync_edge;
    logic              unused_data;

    assign coef_off   = pbus.iaddr_parameter - ADDR_COEF;
    assign wr_coef    = pbus.iparam_wr && (coef_off < ADDR_W'(K));
    assign wr_on      = pbus.iparam_wr && (pbus.iaddr_parameter == ADDR_ON);
    assign wr_cmd     = pbus.iparam_wr && (pbus.iaddr_parameter == ADDR_CMD);
    assign cmd_commit = wr_cmd && pbus.idata_parameter[0];
    assign cmd_abort  = wr_cmd && pbus.idata_parameter[1];
    assign sync_edge  = isync && !isync_d;
    assign unused_data = ^pbus.idata_parameter[15:G_DATAWIDTH];

    // Serial summation reads one shadow coefficient per cycle.
    logic [G_DATAWIDTH-1:0] sel_coef;
    always_comb begin
        sel_coef = '0;
        for (int k = 0; k < K; k++) begin
            if (idx == IDX_W'(k)) sel_coef = shadow[k];
        end
    end

    // FSM state register
    always_ff @(posedge iclk) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next state and control strobes
    logic start_sum, do_copy, set_err;
    always_comb begin
        state_next = state;
        start_sum  = 1'b0;
        do_copy    = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                // Commit wins over abort when both bits are written.
                if (cmd_commit) begin
                    state_next = SUM;
                    start_sum  = 1'b1;
                end
            end
            SUM: begin
                if (idx == IDX_W'(K - 1)) state_next = CHECK;
            end
            CHECK: begin
                if (acc == ACC_W'(G_SUM)) begin
                    state_next = ARMED;
                end else begin
                    state_next = IDLE;
                    set_err    = 1'b1;
                end
            end
            ARMED: begin
                // A sync edge in the same cycle as an abort still commits.
                if (sync_edge) begin
                    state_next = IDLE;
                    do_copy    = 1'b1;
                end else if (cmd_abort) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Banks, accumulator and flags
    always_ff @(posedge iclk) begin
        if (rst_i) begin
            for (int k = 0; k < K; k++) begin
                shadow[k] <= default_coef(k);
                active[k] <= default_coef(k);
            end
            shadow_on <= 1'b1;
            active_on <= 1'b1;
            acc       <= '0;
            idx       <= '0;
            isync_d   <= 1'b0;
            ocommit   <= 1'b0;
            oerr      <= 1'b0;
        end else begin
            isync_d <= isync;
            ocommit <= do_copy;

            // The shadow bank is frozen while a commit is in flight so the
            // checked sum is exactly what gets copied.
            if (state == IDLE) begin
                for (int k = 0; k < K; k++) begin
                    if (wr_coef && coef_off == ADDR_W'(k))
                        shadow[k] <= pbus.idata_parameter[G_DATAWIDTH-1:0];
                end
                if (wr_on) shadow_on <= pbus.idata_parameter[0];
            end

            if (start_sum) begin
                acc  <= '0;
                idx  <= '0;
                oerr <= 1'b0;
            end else if (state == SUM) begin
                acc <= acc + ACC_W'(sel_coef);
                idx <= idx + IDX_W'(1);
            end

            if (set_err) oerr <= 1'b1;

            if (do_copy) begin
                for (int k = 0; k < K; k++) active[k] <= shadow[k];
                active_on <= shadow_on;
            end
        end
    end

    assign obusy     = (state != IDLE);
    assign ogauss_on = active_on;

    // Disabled filter: identity kernel, so the downstream normalising shift
    // passes the centre pixel through unchanged.
    always_comb begin
        og_data = '0;
        for (int k = 0; k < K; k++) begin
            if (active_on)
                og_data[k*G_DATAWIDTH +: G_DATAWIDTH] = active[k];
            else if (k == CENTER)
                og_data[k*G_DATAWIDTH +: G_DATAWIDTH] = G_DATAWIDTH'(G_SUM);
        end
    end
endmodule

// File: tb/tb_gauss_coef_ctrl.sv
// Testbench for gauss_coef_ctrl: table-driven commit transactions, hand-written
// corner sequences and randomized kernels against a transaction-level model.
module tb_gauss_coef_ctrl;
    localparam int W = 10;
    localparam int K = 9;
    localparam logic [15:0] A_COEF = 16'h0200;
    localparam logic [15:0] A_ON   = 16'h001C;
    localparam logic [15:0] A_CMD  = 16'h001F;

    typedef logic [W-1:0] kern_t [K];

    typedef struct {
        kern_t coef;
        bit    on;
        int    sync_at;
        bit    exp_err;
        kern_t exp_k;
        bit    exp_on;
    } vec_t;

    logic           iclk;
    logic           rst_i;
    logic           isync;
    logic [W*K-1:0] og_data;
    logic           ogauss_on, obusy, ocommit, oerr;

    gauss_coef_ctrl_if #(.ADDR_W(16)) pbus ();

    gauss_coef_ctrl dut (
        .iclk      (iclk),
        .rst_i     (rst_i),
        .pbus      (pbus),
        .isync     (isync),
        .og_data   (og_data),
        .ogauss_on (ogauss_on),
        .obusy     (obusy),
        .ocommit   (ocommit),
        .oerr      (oerr)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    int n_tests = 0;
    int n_fail  = 0;

    kern_t DEF, IDENT, KA, KB;
    vec_t  tbl [9];
    logic [W*K-1:0] cur_og;   // expected displayed kernel
    bit             cur_on;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W*K-1:0] pack9(input kern_t a);
        logic [W*K-1:0] p;
        p = '0;
        for (int i = 0; i < K; i++) p[i*W +: W] = a[i];
        return p;
    endfunction

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        pbus.iparam_wr       = 1'b1;
        pbus.iaddr_parameter = addr;
        pbus.idata_parameter = data;
        tick();
        pbus.iparam_wr       = 1'b0;
    endtask

    task automatic write_kernel(input kern_t k, input bit on);
        for (int i = 0; i < K; i++) wr(A_COEF + 16'(i), 16'(k[i]));
        wr(A_ON, {15'd0, on});
    endtask

    // Commit command, then 10 more edges: ARMED if the sum was good.
    task automatic commit_to_armed(input logic [15:0] cmd);
        wr(A_CMD, cmd);
        repeat (10) tick();
    endtask

    task automatic sync_pulse_commit(input string tag, input logic [W*K-1:0] exp_og, input bit exp_on);
        isync = 1'b1;
        tick();
        chk({tag, " ocommit"}, ocommit, 1'b1);
        chk({tag, " og"}, og_data, exp_og);
        chk({tag, " on"}, ogauss_on, exp_on);
        chk({tag, " busy"}, obusy, 1'b0);
        isync = 1'b0;
        tick();
        chk({tag, " ocommit width"}, ocommit, 1'b0);
        cur_og = exp_og;
        cur_on = exp_on;
    endtask

    task automatic run_txn(input kern_t k, input bit on, input int sync_at, input bit exp_err,
                           input logic [W*K-1:0] exp_new, input bit exp_on, input string tag);
        write_kernel(k, on);
        wr(A_CMD, 16'h0001);                       // edge T
        chk({tag, " busy T+1"}, obusy, 1'b1);
        chk({tag, " err cleared"}, oerr, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk({tag, " busy sum"}, obusy, 1'b1);
            chk({tag, " no commit sum"}, ocommit, 1'b0);
        end
        tick();                                    // edge T+10
        chk({tag, " err"}, oerr, exp_err);
        chk({tag, " og hold"}, og_data, cur_og);
        if (exp_err) begin
            chk({tag, " busy after err"}, obusy, 1'b0);
            isync = 1'b1;
            tick();
            isync = 1'b0;
            chk({tag, " sync ignored"}, ocommit, 1'b0);
            tick();
            chk({tag, " og kept"}, og_data, cur_og);
            chk({tag, " on kept"}, ogauss_on, cur_on);
            chk({tag, " err sticky"}, oerr, 1'b1);
        end else begin
            chk({tag, " armed busy"}, obusy, 1'b1);
            for (int e = 11; e < sync_at; e++) begin
                tick();
                chk({tag, " armed busy"}, obusy, 1'b1);
                chk({tag, " armed no commit"}, ocommit, 1'b0);
                chk({tag, " armed og hold"}, og_data, cur_og);
            end
            sync_pulse_commit(tag, exp_new, exp_on);
        end
    endtask

    task automatic do_reset_check(input string tag);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk({tag, " og"}, og_data, pack9(DEF));
        chk({tag, " on"}, ogauss_on, 1'b1);
        chk({tag, " busy"}, obusy, 1'b0);
        chk({tag, " err"}, oerr, 1'b0);
        chk({tag, " ocommit"}, ocommit, 1'b0);
        cur_og = pack9(DEF);
        cur_on = 1'b1;
        for (int i = 0; i < 12; i++) begin
            isync = i[0];
            tick();
            chk({tag, " no commit after"}, ocommit, 1'b0);
        end
        isync = 1'b0;
        chk({tag, " og after"}, og_data, pack9(DEF));
    endtask

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        DEF   = '{16, 32, 16, 32, 64, 32, 16, 32, 16};
        IDENT = '{0, 0, 0, 0, 256, 0, 0, 0, 0};
        KA    = '{28, 28, 28, 28, 32, 28, 28, 28, 28};
        KB    = '{8, 24, 8, 24, 128, 24, 8, 24, 8};

        tbl[0] = '{'{1,2,1,2,244,2,1,2,1}, 1'b1, 20, 1'b0, '{1,2,1,2,244,2,1,2,1}, 1'b1};
        tbl[1] = '{'{16,32,16,32,65,32,16,32,16}, 1'b1, 11, 1'b1, '{1,2,1,2,244,2,1,2,1}, 1'b1};
        tbl[2] = '{'{16,32,16,32,64,32,16,32,16}, 1'b0, 11, 1'b0, '{0,0,0,0,256,0,0,0,0}, 1'b0};
        tbl[3] = '{'{16,32,16,32,64,32,16,32,16}, 1'b1, 13, 1'b0, '{16,32,16,32,64,32,16,32,16}, 1'b1};
        tbl[4] = '{'{0,0,0,0,256,0,0,0,0}, 1'b1, 12, 1'b0, '{0,0,0,0,256,0,0,0,0}, 1'b1};
        tbl[5] = '{'{1023,1023,1023,1023,1023,1023,1023,1023,1023}, 1'b1, 11, 1'b1, '{0,0,0,0,256,0,0,0,0}, 1'b1};
        tbl[6] = '{'{0,0,0,0,0,0,0,0,0}, 1'b1, 11, 1'b1, '{0,0,0,0,256,0,0,0,0}, 1'b1};
        tbl[7] = '{'{28,28,28,28,32,28,28,28,28}, 1'b1, 15, 1'b0, '{28,28,28,28,32,28,28,28,28}, 1'b1};
        tbl[8] = '{'{16,32,16,32,63,32,16,32,16}, 1'b1, 11, 1'b1, '{28,28,28,28,32,28,28,28,28}, 1'b1};

        pbus.iparam_wr       = 1'b0;
        pbus.iaddr_parameter = '0;
        pbus.idata_parameter = '0;
        isync = 1'b0;
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        chk("reset og", og_data, pack9(DEF));
        chk("reset on", ogauss_on, 1'b1);
        chk("reset busy", obusy, 1'b0);
        chk("reset err", oerr, 1'b0);
        chk("reset ocommit", ocommit, 1'b0);
        cur_og = pack9(DEF);
        cur_on = 1'b1;

        for (int r = 0; r < 9; r++)
            run_txn(tbl[r].coef, tbl[r].on, tbl[r].sync_at, tbl[r].exp_err,
                    pack9(tbl[r].exp_k), tbl[r].exp_on, $sformatf("row%0d", r));

        // Writes in ARMED are dropped (active is KA from row 7, shadow KA).
        write_kernel(KB, 1'b1);
        write_kernel(KA, 1'b1);
        commit_to_armed(16'h0001);
        chk("armed wr busy", obusy, 1'b1);
        wr(A_COEF, 16'd5);
        wr(A_ON, 16'd0);
        sync_pulse_commit("armed wr", pack9(KA), 1'b1);
        commit_to_armed(16'h0001);
        chk("armed wr shadow intact", oerr, 1'b0);
        sync_pulse_commit("armed wr recommit", pack9(KA), 1'b1);

        // Coefficient write and second commit during SUM are ignored.
        wr(A_CMD, 16'h0001);                       // edge T
        tick();
        tick();
        wr(A_COEF + 16'd4, 16'd0);                 // edge T+3
        wr(A_CMD, 16'h0001);                       // edge T+4
        repeat (6) tick();                         // edge T+10
        chk("sum wr dropped err", oerr, 1'b0);
        chk("sum armed on time", obusy, 1'b1);
        sync_pulse_commit("sum cmd ignored", pack9(KA), 1'b1);

        // Abort in ARMED: no copy, no error, later sync ignored.
        write_kernel(KB, 1'b1);
        commit_to_armed(16'h0001);
        wr(A_CMD, 16'h0002);
        chk("abort busy", obusy, 1'b0);
        chk("abort err", oerr, 1'b0);
        isync = 1'b1;
        tick();
        isync = 1'b0;
        chk("abort no commit", ocommit, 1'b0);
        tick();
        chk("abort og", og_data, pack9(KA));

        // Abort and sync edge together: commit wins.
        commit_to_armed(16'h0001);
        isync = 1'b1;
        pbus.iparam_wr       = 1'b1;
        pbus.iaddr_parameter = A_CMD;
        pbus.idata_parameter = 16'h0002;
        tick();
        pbus.iparam_wr = 1'b0;
        isync = 1'b0;
        chk("abort+sync ocommit", ocommit, 1'b1);
        chk("abort+sync og", og_data, pack9(KB));
        tick();
        cur_og = pack9(KB);

        // Commit and abort bits together in IDLE: commit wins.
        write_kernel(KA, 1'b1);
        commit_to_armed(16'h0003);
        chk("cmd3 armed", obusy, 1'b1);
        sync_pulse_commit("cmd3", pack9(KA), 1'b1);

        // isync already high on ARMED entry is not an edge.
        write_kernel(KB, 1'b1);
        isync = 1'b1;
        commit_to_armed(16'h0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held sync no commit", ocommit, 1'b0);
            chk("held sync busy", obusy, 1'b1);
        end
        isync = 1'b0;
        tick();
        chk("sync low no commit", ocommit, 1'b0);
        sync_pulse_commit("held sync", pack9(KB), 1'b1);

        // Sync edge in IDLE has no effect.
        isync = 1'b1;
        tick();
        isync = 1'b0;
        chk("idle sync", ocommit, 1'b0);
        chk("idle sync og", og_data, pack9(KB));

        // Randomized kernels against the model: commit only when sum == 256.
        for (int it = 0; it < 40; it++) begin
            kern_t k;
            int    s, p, mode;
            bit    on, err;
            s = 0;
            mode = int'($urandom_range(0, 2));
            for (int i = 0; i < K; i++) begin
                k[i] = (mode == 2) ? W'($urandom_range(0, 1023)) : W'($urandom_range(0, 31));
            end
            if (mode != 2) begin
                p = int'($urandom_range(0, K - 1));
                k[p] = '0;
                for (int i = 0; i < K; i++) s += int'(k[i]);
                k[p] = W'(256 - s);
                if (mode == 1) k[p] = ($urandom_range(0, 1) == 1) ? k[p] + W'(1) : k[p] - W'(1);
            end
            s = 0;
            for (int i = 0; i < K; i++) s += int'(k[i]);
            err = (s != 256);
            on  = ($urandom_range(0, 3) != 0);
            run_txn(k, on, int'($urandom_range(11, 16)), err,
                    pack9(on ? k : IDENT), on, $sformatf("rand%0d", it));
        end

        // Reset during SUM.
        run_txn(KA, 1'b1, 12, 1'b0, pack9(KA), 1'b1, "pre rst");
        write_kernel(KB, 1'b0);
        wr(A_CMD, 16'h0001);
        repeat (3) tick();
        chk("rst sum busy", obusy, 1'b1);
        do_reset_check("rst in sum");

        // Reset during ARMED, then shadow bank must hold the default kernel.
        run_txn(KA, 1'b1, 12, 1'b0, pack9(KA), 1'b1, "pre rst2");
        write_kernel(KB, 1'b0);
        commit_to_armed(16'h0001);
        chk("rst armed busy", obusy, 1'b1);
        do_reset_check("rst in armed");
        commit_to_armed(16'h0001);
        chk("post rst shadow sum", oerr, 1'b0);
        sync_pulse_commit("post rst shadow", pack9(DEF), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gauss_coef_ctrl.md
# gauss_coef_ctrl

Configuration controller for the 3x3 Gaussian filter datapath. It holds a shadow coefficient bank written over the parameter bus, and on a commit request it serially checks that the shadow coefficients sum to `G_SUM`. If they do, it copies the shadow bank into the active bank at the next frame sync rising edge, so the filter never sees a half-updated kernel inside a frame. It also owns the filter enable: when disabled, it drives an identity kernel.

## Interface
- `N`, 3, kernel rows
- `M`, 3, kernel columns
- `G_DATAWIDTH`, 10, coefficient width
- `G_SUM`, 256, required coefficient sum; must equal 2^`G_SUM_W`
- `ADDR_W`, 16, parameter address width
- `ADDR_COEF`, 16'h0200, address of coefficient k=0; coefficient k is at `ADDR_COEF`+k, k=i*M+j
- `ADDR_ON`, 16'h001C, address of the enable register (bit0)
- `ADDR_CMD`, 16'h001F, address of the command register: bit0=commit, bit1=abort
- `iclk`  in  1  clock; the block has one clock
- `rst_i`  in  1  reset, synchronous and active-high
- `iparam_wr`  in  1  parameter write strobe
- `iaddr_parameter`  in  `ADDR_W`  write address
- `idata_parameter`  in  16  write data; coefficients use bits [`G_DATAWIDTH`-1:0]
- `isync`  in  1  frame sync from the video timing
- `og_data`  out  `G_DATAWIDTH`*N*M  active kernel; coefficient k is at bits [(k+1)*`G_DATAWIDTH`-1 : k*`G_DATAWIDTH`]
- `ogauss_on`  out  1  active enable
- `obusy`  out  1  high in SUM, CHECK and ARMED
- `ocommit`  out  1  one-cycle pulse when the active bank is updated
- `oerr`  out  1  sticky sum-mismatch flag

## Operation
- **Reset values.**
  - Shadow bank and active bank both hold {16,32,16,32,64,32,16,32,16} for k=0..8.
  - Shadow enable and active enable = 1.
  - `obusy` = 0, `ocommit` = 0, `oerr` = 0.
  - State = IDLE, accumulator = 0, `isync_d` = 0.
- **Writes.**
  - A write to `ADDR_COEF`+k (k<N*M) updates shadow coefficient k, but only in IDLE.
  - A write to `ADDR_ON` updates the shadow enable, but only in IDLE.
  - Writes outside IDLE are dropped silently.
  - Writes to any other address are ignored.
- **FSM: IDLE -> SUM -> CHECK -> ARMED -> IDLE.**
  - IDLE: a write to `ADDR_CMD` with bit0=1 clears `oerr`, clears the accumulator and index, and moves to SUM.
  - SUM: adds shadow coefficient[index] per cycle for N*M cycles, zero-extended. Moves to CHECK after index N*M-1.
  - CHECK: compares the accumulator with `G_SUM`.
    - Equal: moves to ARMED.
    - Not equal: sets `oerr` and returns to IDLE; the active bank is unchanged.
  - ARMED: waits for a sync rising edge, defined as `isync`=1 and `isync_d`=0, where `isync_d` is `isync` registered.
    - On the edge: copies the shadow bank and shadow enable to the active bank, pulses `ocommit`, and returns to IDLE.
    - A write to `ADDR_CMD` with bit1=1 aborts to IDLE with no copy and no error.
- **Command conflicts.**
  - A commit command outside IDLE is ignored.
  - If bit0 and bit1 are both set in IDLE, the commit wins.
  - If an abort and a sync edge arrive in the same cycle in ARMED, the commit wins.
- **Width rules.**
  - Accumulator width = `G_DATAWIDTH`+ceil(log2(N*M)), which is 14 bits at the defaults. It never overflows.
- **Output mapping.**
  - `ogauss_on`=1: `og_data` = the active bank.
  - `ogauss_on`=0: `og_data` = identity kernel, i.e. the centre coefficient (k=(N*M-1)/2) = `G_SUM` and all others = 0. This makes the downstream sum>>`G_SUM_W` pass the centre pixel through.
- **Sync handling.** A sync edge outside ARMED has no effect. `isync_d` updates every cycle in every state.
- **Reset mid-operation.** Reset in any state restores all reset values, including the default kernel in both banks.

## Timing
- The commit command is sampled at edge T:
  - SUM occupies cycles T+1..T+N*M.
  - CHECK occupies cycle T+N*M+1.
  - ARMED begins at T+N*M+2, i.e. T+11 at the defaults.
- `oerr` rises in the cycle after CHECK, i.e. T+11.
- In ARMED, a sync edge sampled at edge S gives:
  - `og_data`, `ogauss_on` and `ocommit`=1 are visible from S+1.
  - `ocommit` is high for exactly one cycle.
  - `obusy` falls at S+1.
- `og_data` and `ogauss_on` are registered. They change only at reset or on a commit cycle.
- There is no combinational path from the parameter bus to `og_data`.

## Test plan
- Reset, no writes -> `og_data` = {16,32,16,32,64,32,16,32,16}, `ogauss_on`=1, `obusy`=0, `oerr`=0.
- Write coefficients {1,2,1,2,244,2,1,2,1} (sum 256), then commit, then pulse `isync` at T+20:
  - `obusy` is high over T+1..T+20.
  - `og_data` updates and `ocommit` pulses at T+21.
  - `og_data` is unchanged before T+21.
- Write coefficient k=4 as 65 (sum 257), then commit -> `oerr`=1 at T+11, state returns to IDLE, active bank unchanged, later sync edges have no effect.
- Write `ADDR_ON`=0, commit, then sync -> `ogauss_on`=0 and `og_data` centre=256, others 0. Then write `ADDR_ON`=1, commit, sync -> the previous active kernel returns.
- In ARMED:
  - A coefficient write is dropped; it is absent after the commit.
  - Abort (data=2) -> IDLE with no `ocommit` on the next sync.
  - Abort and sync edge in the same cycle -> the commit happens.
- Assert `rst_i` during SUM and again during ARMED -> both banks return to the default kernel, `obusy`=0, and no `ocommit` follows.
